// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared definitions for the load/store front end.
//   - `WORD_SIZE (data/address width, 32)
//   - load/store opcode constants
//   - 2-bit FSM state encoding
//   - opcode classification and alignment helpers
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LD_WAIT  = 2'd1,
    ST_RMW_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Halves need an even address, words need a 4-byte aligned address.
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lo[0];
      OP_LW, OP_SW:         return lo != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// lane_align: combinational byte-lane handling for mem_access_unit.
//   opcode    in  6          selects size and sign
//   addr_lo   in  2          Address[1:0], little-endian lane select
//   rdata     in  WORD_SIZE  word read from memory
//   wdata     in  WORD_SIZE  store data (low byte/half used for sb/sh)
//   load_data out WORD_SIZE  extracted and sign/zero-extended load value
//   merged    out WORD_SIZE  rdata with the addressed lane replaced (sb/sh)
module lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]            opcode,
  input  logic [1:0]            addr_lo,
  input  logic [`WORD_SIZE-1:0] rdata,
  input  logic [`WORD_SIZE-1:0] wdata,
  output logic [`WORD_SIZE-1:0] load_data,
  output logic [`WORD_SIZE-1:0] merged
);

  logic [4:0]  bshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    bshift = {addr_lo, 3'b000};
    rbyte  = rdata[bshift +: 8];
    rhalf  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (opcode)
      OP_LB:   load_data = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  load_data = {24'h0, rbyte};
      OP_LH:   load_data = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  load_data = {16'h0, rhalf};
      default: load_data = rdata;
    endcase

    merged = rdata;
    case (opcode)
      OP_SB: merged[bshift +: 8] = wdata[7:0];
      OP_SH: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front end over a word memory.
//   clk, rst_n            clock, synchronous active-low reset
//   MemRead, MemWrite     datapath request strobes
//   opcode                lb/lh/lw/lbu/lhu/sb/sh/sw
//   Address, WriteData    byte address and store data (held while stalled)
//   LoadData              registered, extended load result
//   Stall                 datapath must hold this cycle
//   AddrErr               one-cycle error pulse
//   mem_read, mem_write   memory strobes
//   mem_addr, mem_wdata   word index and write data to memory
//   mem_rdata             memory read data (valid the cycle after mem_read)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [5:0]            opcode,
  input  logic [`WORD_SIZE-1:0] Address,
  input  logic [`WORD_SIZE-1:0] WriteData,
  output logic [`WORD_SIZE-1:0] LoadData,
  output logic                  Stall,
  output logic                  AddrErr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [`WORD_SIZE-1:0] mem_addr,
  output logic [`WORD_SIZE-1:0] mem_wdata,
  input  logic [`WORD_SIZE-1:0] mem_rdata
);

  state_t state, state_nx;
  logic [`WORD_SIZE-1:0] ld_ext;
  logic [`WORD_SIZE-1:0] merged;
  logic                  legal;
  logic                  err;
  logic                  unused_addr_hi;

  lane_align u_lane_align (
    .opcode    (opcode),
    .addr_lo   (Address[1:0]),
    .rdata     (mem_rdata),
    .wdata     (WriteData),
    .load_data (ld_ext),
    .merged    (merged)
  );

  // Bits above the word index wrap and are deliberately ignored.
  assign unused_addr_hi = ^Address[`WORD_SIZE-1:MEM_DEPTH_LOG2+2];

  always_comb begin
    mem_addr = '0;
    mem_addr[MEM_DEPTH_LOG2-1:0] = Address[MEM_DEPTH_LOG2+1:2];
    // The RMW write reuses the same index; only the data differs.
    mem_wdata = (state == ST_RMW_WAIT) ? merged : WriteData;
  end

  always_comb begin
    Stall     = 1'b0;
    AddrErr   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    state_nx  = state;
    // The strobe must match the opcode class: a load opcode with MemWrite
    // (or vice versa) is treated as an unknown access.
    legal = MemRead ? is_load(opcode) : is_store(opcode);
    err   = (MemRead || MemWrite) &&
            ((MemRead && MemWrite) || !legal || misaligned(opcode, Address[1:0]));

    case (state)
      ST_IDLE: begin
        if (err) begin
          AddrErr = 1'b1;
        end else if (MemWrite && opcode == OP_SW) begin
          mem_write = 1'b1;
        end else if (MemRead) begin
          mem_read = 1'b1;
          Stall    = 1'b1;
          state_nx = ST_LD_WAIT;
        end else if (MemWrite) begin
          mem_read = 1'b1;
          Stall    = 1'b1;
          state_nx = ST_RMW_WAIT;
        end
      end
      ST_LD_WAIT: begin
        Stall    = 1'b1;
        state_nx = ST_RESP;
      end
      ST_RMW_WAIT: begin
        mem_write = 1'b1;
        Stall     = 1'b1;
        state_nx  = ST_RESP;
      end
      default: state_nx = ST_IDLE;
    endcase

    if (!rst_n) begin
      Stall     = 1'b0;
      AddrErr   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      LoadData <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_LD_WAIT) LoadData <= ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit with
// a word memory model (read data registered on mem_read, 0 otherwise).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [5:0]  opcode;
  logic [31:0] Address, WriteData;
  logic [31:0] LoadData;
  logic        Stall, AddrErr, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_idx;
  logic [31:0] bd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_DEPTH_LOG2(10)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .opcode(opcode), .Address(Address), .WriteData(WriteData),
    .LoadData(LoadData), .Stall(Stall), .AddrErr(AddrErr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    mem_rdata <= mem_read ? mem[mem_addr[9:0]] : 32'h0;
    if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
    if (bd_we) mem[bd_idx] <= bd_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic idle();
    MemRead = 0; MemWrite = 0; opcode = 6'h00; Address = '0; WriteData = '0;
  endtask

  // 3-cycle load: request, LD_WAIT, RESP.
  task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] exp, input logic [31:0] exp_idx);
    MemRead = 1; MemWrite = 0; opcode = op; Address = a;
    #1;
    chk({tag, " c1 Stall"},    32'(Stall), 32'd1);
    chk({tag, " c1 mem_read"}, 32'(mem_read), 32'd1);
    chk({tag, " c1 mem_addr"}, mem_addr, exp_idx);
    chk({tag, " c1 AddrErr"},  32'(AddrErr), 32'd0);
    tick();
    chk({tag, " c2 Stall"},    32'(Stall), 32'd1);
    chk({tag, " c2 strobes"},  {30'h0, mem_read, mem_write}, 32'd0);
    tick();
    chk({tag, " c3 Stall"},    32'(Stall), 32'd0);
    chk({tag, " c3 strobes"},  {30'h0, mem_read, mem_write}, 32'd0);
    chk({tag, " LoadData"},    LoadData, exp);
    tick();
    idle();
  endtask

  // 3-cycle partial store: read, RMW write, RESP.
  task automatic do_pstore(input string tag, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_merged);
    MemRead = 0; MemWrite = 1; opcode = op; Address = a; WriteData = wd;
    #1;
    chk({tag, " c1 rd/wr"}, {30'h0, mem_read, mem_write}, 32'd2);
    chk({tag, " c1 Stall"}, 32'(Stall), 32'd1);
    tick();
    chk({tag, " c2 rd/wr"},  {30'h0, mem_read, mem_write}, 32'd1);
    chk({tag, " c2 Stall"},  32'(Stall), 32'd1);
    chk({tag, " c2 wdata"},  mem_wdata, exp_merged);
    tick();
    chk({tag, " c3 rd/wr"},  {30'h0, mem_read, mem_write}, 32'd0);
    chk({tag, " c3 Stall"},  32'(Stall), 32'd0);
    tick();
    idle();
  endtask

  initial begin
    bd_we = 0; bd_idx = '0; bd_data = '0;
    idle();
    rst_n = 0;
    #1;
    chk("reset strobes", {28'h0, Stall, AddrErr, mem_read, mem_write}, 32'd0);
    tick();
    tick();
    chk("reset LoadData", LoadData, 32'h0);
    rst_n = 1;
    preload(10'h040, 32'h80FF_1234);
    preload(10'h03F, 32'h5A5A_5A5A);
    #1;
    chk("idle strobes", {28'h0, Stall, AddrErr, mem_read, mem_write}, 32'd0);

    do_load("lb 0x103",  6'h20, 32'h0000_0103, 32'hFFFF_FF80, 32'h40);
    do_load("lbu 0x103", 6'h24, 32'h0000_0103, 32'h0000_0080, 32'h40);
    do_load("lhu 0x102", 6'h25, 32'h0000_0102, 32'h0000_80FF, 32'h40);
    do_load("lh 0x102",  6'h21, 32'h0000_0102, 32'hFFFF_80FF, 32'h40);
    do_load("lh 0x100",  6'h21, 32'h0000_0100, 32'h0000_1234, 32'h40);
    do_load("lb 0x101",  6'h20, 32'h0000_0101, 32'h0000_0012, 32'h40);
    do_load("lw wrap",   6'h23, 32'h1000_0100, 32'h80FF_1234, 32'h40);

    preload(10'h040, 32'h1122_3344);
    do_pstore("sb 0x101", 6'h28, 32'h0000_0101, 32'hFFFF_FFAB, 32'h1122_AB44);
    chk("sb mem", mem[10'h040], 32'h1122_AB44);
    do_pstore("sh 0x102", 6'h29, 32'h0000_0102, 32'h1234_BEEF, 32'hBEEF_AB44);
    chk("sh mem", mem[10'h040], 32'hBEEF_AB44);

    // sw: single cycle, no stall
    MemWrite = 1; opcode = 6'h2B; Address = 32'h20; WriteData = 32'hDEAD_BEEF;
    #1;
    chk("sw strobes", {29'h0, Stall, mem_read, mem_write}, 32'd1);
    chk("sw mem_addr", mem_addr, 32'h8);
    chk("sw wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    idle();
    #1;
    chk("sw after Stall", 32'(Stall), 32'd0);
    chk("sw mem", mem[10'h008], 32'hDEAD_BEEF);
    do_load("lw 0x20", 6'h23, 32'h20, 32'hDEAD_BEEF, 32'h8);

    // Error cases: AddrErr pulse, no strobes, nothing changes
    MemRead = 1; opcode = 6'h23; Address = 32'h102;
    #1;
    chk("lw misalign err", {28'h0, Stall, AddrErr, mem_read, mem_write}, 32'd4);
    tick();
    idle();
    MemWrite = 1; opcode = 6'h29; Address = 32'h0FF; WriteData = 32'h7777;
    #1;
    chk("sh misalign err", {28'h0, Stall, AddrErr, mem_read, mem_write}, 32'd4);
    tick();
    idle();
    MemRead = 1; MemWrite = 1; opcode = 6'h23; Address = 32'h100;
    #1;
    chk("rd+wr err", {28'h0, Stall, AddrErr, mem_read, mem_write}, 32'd4);
    tick();
    idle();
    MemRead = 1; opcode = 6'h22; Address = 32'h100;
    #1;
    chk("bad opcode err", {28'h0, Stall, AddrErr, mem_read, mem_write}, 32'd4);
    tick();
    idle();
    #1;
    chk("err pulse ends", 32'(AddrErr), 32'd0);
    chk("err LoadData", LoadData, 32'hDEAD_BEEF);
    chk("err mem 0x40", mem[10'h040], 32'hBEEF_AB44);
    chk("err mem 0x3F", mem[10'h03F], 32'h5A5A_5A5A);

    // Reset during RMW_WAIT of sh aborts the write
    MemWrite = 1; opcode = 6'h29; Address = 32'h100; WriteData = 32'h0000_9999;
    #1;
    chk("rst sh c1 rd", 32'(mem_read), 32'd1);
    tick();
    rst_n = 0;
    #1;
    chk("rst sh c2 strobes", {28'h0, Stall, AddrErr, mem_read, mem_write}, 32'd0);
    tick();
    rst_n = 1;
    idle();
    #1;
    chk("rst sh LoadData", LoadData, 32'h0);
    chk("rst sh mem", mem[10'h040], 32'hBEEF_AB44);
    chk("rst sh idle", {28'h0, Stall, AddrErr, mem_read, mem_write}, 32'd0);
    // A fresh load proves the FSM restarted from IDLE
    do_load("lw after rst", 6'h23, 32'h100, 32'hBEEF_AB44, 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
